// File: rtl/shift_sequencer.sv
// Frame controller that serialises a captured parallel word through an external
// shift register. Optional trailing even-parity bit is compiled in with SHSEQ_PARITY_EN.
module shift_sequencer #(
   parameter int unsigned N = 4
) (
   input  logic         Clock,
   input  logic         Reset,
   input  logic         Start,
   input  logic         Abort,
   input  logic [N-1:0] Data,
   input  logic         Dir,
   input  logic         Fill,
   input  logic [N-1:0] Q,
   output logic [1:0]   Status,
   output logic         W,
   output logic [N-1:0] I,
   output logic         SerialOut,
   output logic         Busy,
   output logic         Done
);

   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] ST_HOLD  = 2'd0;
   localparam logic [1:0] ST_LEFT  = 2'd1;
   localparam logic [1:0] ST_RIGHT = 2'd2;
   localparam logic [1:0] ST_LOAD  = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_SHIFT  = 3'd2,
`ifdef SHSEQ_PARITY_EN
      S_PARITY = 3'd3,
`endif
      S_DONE   = 3'd4
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            dir_q, dir_d;
   logic            fill_q, fill_d;
   logic [N-1:0]    data_q, data_d;
   logic [1:0]      status_q, status_d;
   logic            w_q, w_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   // State, captured frame parameters and registered outputs
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         dir_q    <= 1'b0;
         fill_q   <= 1'b0;
         data_q   <= '0;
         status_q <= ST_HOLD;
         w_q      <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         dir_q    <= dir_d;
         fill_q   <= fill_d;
         data_q   <= data_d;
         status_q <= status_d;
         w_q      <= w_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   // Next-state and capture logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      fill_d  = fill_q;
      data_d  = data_q;
      case (state_q)
         S_IDLE: begin
            if (Start) begin
               state_d = S_LOAD;
               data_d  = Data;
               dir_d   = Dir;
               fill_d  = Fill;
            end
         end
         S_LOAD: begin
            cnt_d   = '0;
            state_d = Abort ? S_IDLE : S_SHIFT;
         end
         S_SHIFT: begin
            if (Abort) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CW'(N - 1)) begin
               cnt_d = '0;
`ifdef SHSEQ_PARITY_EN
               state_d = S_PARITY;
`else
               state_d = S_DONE;
`endif
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
`ifdef SHSEQ_PARITY_EN
         S_PARITY: state_d = Abort ? S_IDLE : S_DONE;
`endif
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Output decode from the upcoming state so the pins are registered
   always_comb begin
      status_d = ST_HOLD;
      w_d      = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      case (state_d)
         S_LOAD: begin
            status_d = ST_LOAD;
            busy_d   = 1'b1;
         end
         S_SHIFT: begin
            status_d = dir_d ? ST_RIGHT : ST_LEFT;
            w_d      = fill_d;
            busy_d   = 1'b1;
         end
`ifdef SHSEQ_PARITY_EN
         S_PARITY: busy_d = 1'b1;
`endif
         S_DONE:   done_d = 1'b1;
         default:  ;
      endcase
   end

   // Outgoing bit: register edge bit while shifting, parity bit afterwards
   always_comb begin
      SerialOut = 1'b0;
      case (state_q)
         S_SHIFT:  SerialOut = dir_q ? Q[0] : Q[N-1];
`ifdef SHSEQ_PARITY_EN
         S_PARITY: SerialOut = ^data_q;
`endif
         default:  SerialOut = 1'b0;
      endcase
   end

   assign Status = status_q;
   assign W      = w_q;
   assign I      = data_q;
   assign Busy   = busy_q;
   assign Done   = done_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer driving a behavioural 4-bit shift register.
module tb_shift_sequencer;

   localparam int unsigned N = 4;

   logic         Clock;
   logic         Reset;
   logic         Start;
   logic         Abort;
   logic [N-1:0] Data;
   logic         Dir;
   logic         Fill;
   logic [N-1:0] Q;
   logic [1:0]   Status;
   logic         W;
   logic [N-1:0] I;
   logic         SerialOut;
   logic         Busy;
   logic         Done;

   int total;
   int bad;

   shift_sequencer #(.N(N)) dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .Start     (Start),
      .Abort     (Abort),
      .Data      (Data),
      .Dir       (Dir),
      .Fill      (Fill),
      .Q         (Q),
      .Status    (Status),
      .W         (W),
      .I         (I),
      .SerialOut (SerialOut),
      .Busy      (Busy),
      .Done      (Done)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Shift register datapath model: 0 hold, 1 left, 2 right, 3 load
   always_ff @(posedge Clock) begin
      case (Status)
         2'd1:    Q <= {Q[N-2:0], W};
         2'd2:    Q <= {W, Q[N-1:1]};
         2'd3:    Q <= I;
         default: Q <= Q;
      endcase
   end

   typedef struct {
      logic [N-1:0] data;
      logic         dir;
      logic         fill;
      logic [N-1:0] seq;    // serial bits in send order, first bit written leftmost
      logic [N-1:0] q_end;
      logic         par;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic run_frame(input vec_t v, input string tag);
      Data  = v.data;
      Dir   = v.dir;
      Fill  = v.fill;
      Start = 1'b1;
      step();
      Start = 1'b0;
      chk({tag, "_load_status"}, 32'(Status), 32'd3);
      chk({tag, "_load_busy"}, 32'(Busy), 32'd1);
      chk({tag, "_load_i"}, 32'(I), 32'(v.data));
      for (int k = 0; k < int'(N); k++) begin
         step();
         chk($sformatf("%s_shift%0d_status", tag, k), 32'(Status), v.dir ? 32'd2 : 32'd1);
         chk($sformatf("%s_shift%0d_w", tag, k), 32'(W), 32'(v.fill));
         chk($sformatf("%s_shift%0d_serial", tag, k), 32'(SerialOut), 32'(v.seq[N-1-k]));
      end
      step();
`ifdef SHSEQ_PARITY_EN
      chk({tag, "_par_status"}, 32'(Status), 32'd0);
      chk({tag, "_par_serial"}, 32'(SerialOut), 32'(v.par));
      chk({tag, "_par_done"}, 32'(Done), 32'd0);
      step();
`endif
      chk({tag, "_done"}, 32'(Done), 32'd1);
      chk({tag, "_done_busy"}, 32'(Busy), 32'd0);
      chk({tag, "_done_status"}, 32'(Status), 32'd0);
      chk({tag, "_done_serial"}, 32'(SerialOut), 32'd0);
      chk({tag, "_q_end"}, 32'(Q), 32'(v.q_end));
      step();
      chk({tag, "_done_pulse"}, 32'(Done), 32'd0);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      Reset = 1'b0;
      Start = 1'b0;
      Abort = 1'b0;
      Data  = '0;
      Dir   = 1'b0;
      Fill  = 1'b0;

      vecs[0] = '{data: 4'b1101, dir: 1'b0, fill: 1'b0, seq: 4'b1101, q_end: 4'b0000, par: 1'b1};
      vecs[1] = '{data: 4'b1101, dir: 1'b1, fill: 1'b1, seq: 4'b1011, q_end: 4'b1111, par: 1'b1};
      vecs[2] = '{data: 4'b1001, dir: 1'b0, fill: 1'b1, seq: 4'b1001, q_end: 4'b1111, par: 1'b0};
      vecs[3] = '{data: 4'b0110, dir: 1'b1, fill: 1'b0, seq: 4'b0110, q_end: 4'b0000, par: 1'b0};
      vecs[4] = '{data: 4'b1000, dir: 1'b1, fill: 1'b1, seq: 4'b0001, q_end: 4'b1111, par: 1'b1};

      #1;
      chk("rst_status", 32'(Status), 32'd0);
      chk("rst_busy", 32'(Busy), 32'd0);
      chk("rst_done", 32'(Done), 32'd0);
      chk("rst_i", 32'(I), 32'd0);
      chk("rst_w", 32'(W), 32'd0);
      chk("rst_serial", 32'(SerialOut), 32'd0);
      step();
      step();
      Reset = 1'b1;
      step();

      for (int v = 0; v < 5; v++) run_frame(vecs[v], $sformatf("vec%0d", v));

      // Start held high with Data changing mid-frame
      Data  = 4'b1101;
      Dir   = 1'b0;
      Fill  = 1'b0;
      Start = 1'b1;
      step();
      chk("held_load_i", 32'(I), 32'b1101);
      for (int k = 0; k < int'(N); k++) begin
         step();
         if (k == 0) Data = 4'b0110;
         chk($sformatf("held_shift%0d_serial", k), 32'(SerialOut), 32'(vecs[0].seq[N-1-k]));
         chk($sformatf("held_shift%0d_i", k), 32'(I), 32'b1101);
      end
      step();
`ifdef SHSEQ_PARITY_EN
      chk("held_par_serial", 32'(SerialOut), 32'd1);
      step();
`endif
      chk("held_done", 32'(Done), 32'd1);
      chk("held_done_i", 32'(I), 32'b1101);
      step();
      chk("held_idle_status", 32'(Status), 32'd0);
      chk("held_idle_busy", 32'(Busy), 32'd0);
      step();
      Start = 1'b0;
      chk("held_second_status", 32'(Status), 32'd3);
      chk("held_second_i", 32'(I), 32'b0110);
      begin
         bit seen;
         seen = 1'b0;
         for (int c = 0; c < 20 && !seen; c++) begin
            step();
            if (Done) seen = 1'b1;
         end
         chk("held_second_done_seen", 32'(seen), 32'd1);
      end
      step();

      // Abort in the second shift cycle
      Data  = 4'b1101;
      Dir   = 1'b0;
      Fill  = 1'b0;
      Start = 1'b1;
      step();
      Start = 1'b0;
      step();
      step();
      Abort = 1'b1;
      chk("abort_c3_serial", 32'(SerialOut), 32'd1);
      step();
      Abort = 1'b0;
      chk("abort_status", 32'(Status), 32'd0);
      chk("abort_busy", 32'(Busy), 32'd0);
      chk("abort_done", 32'(Done), 32'd0);
      chk("abort_serial", 32'(SerialOut), 32'd0);
      chk("abort_q", 32'(Q), 32'b0100);
      step();
      chk("abort_no_done", 32'(Done), 32'd0);
      chk("abort_q_hold", 32'(Q), 32'b0100);

      // Reset mid-frame
      Data  = 4'b1101;
      Dir   = 1'b1;
      Fill  = 1'b1;
      Start = 1'b1;
      step();
      Start = 1'b0;
      step();
      step();
      Reset = 1'b0;
      #1;
      chk("midrst_status", 32'(Status), 32'd0);
      chk("midrst_w", 32'(W), 32'd0);
      chk("midrst_i", 32'(I), 32'd0);
      chk("midrst_serial", 32'(SerialOut), 32'd0);
      chk("midrst_busy", 32'(Busy), 32'd0);
      chk("midrst_done", 32'(Done), 32'd0);
      step();
      step();
      Reset = 1'b1;
      step();
      chk("midrst_no_done", 32'(Done), 32'd0);
      run_frame('{data: 4'b1001, dir: 1'b0, fill: 1'b0, seq: 4'b1001, q_end: 4'b0000, par: 1'b0},
                "post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Frame controller that drives a `ShiftRegister` instance through its Status/W/I control pins to serialise a parallel word. On a Start handshake it captures a word, issues one load cycle, then N shift cycles in the selected direction, and presents each outgoing bit on SerialOut. It sits between a parallel producer and the shift-register datapath, and is the only block permitted to drive that register's control pins.

## Interface

- N, 4, register width in bits; N ≥ 2.
- Clock  in  1  rising-edge clock, shared with the ShiftRegister.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  frame request; sampled only in IDLE.
- Abort  in  1  synchronous frame cancel; sampled in LOAD/SHIFT/PARITY.
- Data  in  N  parallel word; captured when Start is accepted.
- Dir  in  1  0 = left shift, MSB first; 1 = right shift, LSB first. Captured with Data.
- Fill  in  1  serial fill bit shifted in; captured with Data.
- Q  in  N  ShiftRegister output.
- Status  out  2  to ShiftRegister: 0 hold, 1 left, 2 right, 3 load.
- W  out  1  to ShiftRegister serial input.
- I  out  N  to ShiftRegister parallel input.
- SerialOut  out  1  current outgoing bit.
- Busy  out  1  frame in progress.
- Done  out  1  one-cycle completion pulse.

## Operation

- States: IDLE, LOAD, SHIFT, PARITY (only when the macro is defined), DONE.
- IDLE: Status=0, Busy=0, SerialOut=0. Start=1 at an edge captures Data→I, and latches Dir and Fill. Next state is LOAD.
- LOAD: Status=3 for exactly one cycle; the register loads I at the closing edge. Next state is SHIFT with the counter at 0.
- SHIFT: Status=1 when Dir=0, Status=2 when Dir=1. W=latched Fill.
  - SerialOut=Q[N-1] when Dir=0, Q[0] when Dir=1 (combinational from Q).
  - The counter increments each edge. After the edge with counter=N-1, the next state is PARITY if present, otherwise DONE.
- PARITY: Status=0; SerialOut=^I (XOR of captured word). Next state is DONE.
- DONE: Status=0, Done=1, Busy=0, SerialOut=0. Next state is IDLE. Start is ignored in DONE.
- Abort=1 in LOAD/SHIFT/PARITY: next state is IDLE, Status=0 from the next cycle, no Done pulse. Register contents are left as-is.
- Start while Busy is ignored. Data, Dir and Fill changes while Busy have no effect; I is stable from capture until the next accepted Start.
- Busy = state ∈ {LOAD, SHIFT, PARITY}.
- The counter is $clog2(N) bits and never exceeds N-1.
- Reset asserted (Reset=0) takes effect immediately:
  - state is IDLE;
  - Status=0, W=0, I=0, SerialOut=0, Busy=0, Done=0, counter=0.
  - Mid-frame reset abandons the frame with no Done pulse.

## Timing

- Cycle numbering: Start is accepted at edge 0, so cycle 1 = LOAD.
- Cycles 2..N+1 = SHIFT. Bit i appears on SerialOut in cycle 2+i, valid for the full cycle before the shifting edge.
- DONE is cycle N+2 without parity, N+3 with parity. The next Start is accepted in cycle N+3 (N+4 with parity).
- Minimum frame period: N+3 cycles (N+4 with parity).
- All outputs are registered except SerialOut, which is a combinational mux of Q or I, gated by state.

## Configuration

- SHSEQ_PARITY_EN defined: the PARITY state is present. One even-parity bit (^Data) follows the N data bits, and the frame period grows by one cycle.
- SHSEQ_PARITY_EN undefined: PARITY is not compiled in, and SHIFT goes directly to DONE.

## Test plan

All scenarios use N=4, a ClockGenerator-driven Clock, and a ShiftRegister #(4) wired to Status/W/I/Q.

- Start, Data=1101, Dir=0, Fill=0 → Status 3 in cycle 1, then 1 for cycles 2–5. SerialOut 1,1,0,1. Q=0000 after cycle 5. Done=1 in cycle 6 only.
- Start, Data=1101, Dir=1, Fill=1 → Status 2 for cycles 2–5. SerialOut 1,0,1,1. Q=1111 after cycle 5.
- Start held high for the whole frame, with Data changed to 0110 in cycle 2 → I stays 1101 and SerialOut is unchanged. The second frame starts at cycle 7 with I=0110.
- Abort=1 in cycle 3 of a Dir=0, Data=1101 frame → Status=0 and Busy=0 from cycle 4. No Done pulse. Q holds the value after two shifts (0100).
- Reset=0 during cycle 3 → all outputs 0 immediately. After Reset=1, a Start with Data=1001 runs a normal frame with SerialOut 1,0,0,1.
- With SHSEQ_PARITY_EN defined, Data=1101, Dir=0 → SerialOut 1,1,0,1, then the parity bit 1 in cycle 6. Done in cycle 7.
